// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared widths, flag bit indices, op-byte constants and the sequencer state enum
package alu_sequencer_pkg;
  localparam int BUS_W = 8;
  localparam int FLAG_W = 3;
  localparam int FL_CARRY = 0;
  localparam int FL_LT = 1;
  localparam int FL_Z = 2;
  localparam logic [BUS_W-1:0] OP_ADD = 8'h20;
  localparam logic [BUS_W-1:0] OP_SUB = 8'h60;
  localparam logic [BUS_W-1:0] OP_NAND = 8'h30;
  typedef enum logic [3:0] {
    IDLE, A_SET, A_CAP, B_SET, B_CAP, X_SET, X_CAP, F_CAP, R_SET, R_CAP, DONE
  } state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request (start/skip_ab/op/operands), bus (bus_out/bus_oe_n/bus_in), strobes, flags in, status out; master = sequencer
interface alu_seq_if;
  import alu_sequencer_pkg::*;
  logic start, skip_ab;
  logic [BUS_W-1:0] op, operand_a, operand_b, bus_in, bus_out, result;
  logic fl_carry, fl_lt, fl_z;
  logic bus_oe_n, a_r, b_r, o_r, flb_r, fl_r, o_w, a_bus, b_bus, busy, done;
  logic [FLAG_W-1:0] flags;
  modport master (
    input start, skip_ab, op, operand_a, operand_b, bus_in, fl_carry, fl_lt, fl_z,
    output bus_out, bus_oe_n, a_r, b_r, o_r, flb_r, fl_r, o_w, a_bus, b_bus, busy, done, result, flags
  );
  modport slave (
    output start, skip_ab, op, operand_a, operand_b, bus_in, fl_carry, fl_lt, fl_z,
    input bus_out, bus_oe_n, a_r, b_r, o_r, flb_r, fl_r, o_w, a_bus, b_bus, busy, done, result, flags
  );
endinterface

// File: rtl/alu_seq_strobe_gen.sv
// alu_seq_strobe_gen: registers bus/strobe/status outputs from the state being entered (nxt) so they align with state; in: clk, rst, nxt, a, b, op; out: bus and strobes
module alu_seq_strobe_gen
  import alu_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  state_t           nxt,
  input  logic [BUS_W-1:0] a,
  input  logic [BUS_W-1:0] b,
  input  logic [BUS_W-1:0] op,
  output logic [BUS_W-1:0] bus_out,
  output logic             bus_oe_n,
  output logic             a_r,
  output logic             b_r,
  output logic             o_r,
  output logic             flb_r,
  output logic             fl_r,
  output logic             o_w,
  output logic             busy,
  output logic             done
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_out <= '0;
      bus_oe_n <= 1'b1;
      {a_r, b_r, o_r, flb_r, fl_r} <= '0;
      o_w <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      bus_out <= (nxt inside {A_SET, A_CAP}) ? a :
                 (nxt inside {B_SET, B_CAP}) ? b :
                 (nxt inside {X_SET, X_CAP}) ? op : '0;
      bus_oe_n <= !(nxt inside {[A_SET:X_CAP]});
      a_r <= nxt == A_CAP;
      b_r <= nxt == B_CAP;
      o_r <= nxt == X_CAP;
      flb_r <= nxt == X_CAP;
      fl_r <= nxt == F_CAP;
      o_w <= !(nxt inside {R_SET, R_CAP});
      busy <= nxt != IDLE;
      done <= nxt == DONE;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs load A/B, execute, flag latch and result readback on start; ports: clk, rst, s (alu_seq_if.master)
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input logic      clk,
  input logic      rst,
  alu_seq_if.master s
);
  state_t state, nxt;
  logic accept;
  logic [BUS_W-1:0] cap_a, cap_b, cap_op, a_d, b_d, op_d, result;
  logic [FLAG_W-1:0] flags;
  assign accept = state == IDLE && s.start;
  assign a_d = accept ? s.operand_a : cap_a;
  assign b_d = accept ? s.operand_b : cap_b;
  assign op_d = accept ? s.op : cap_op;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cap_a <= '0;
      cap_b <= '0;
      cap_op <= '0;
      result <= '0;
      flags <= '0;
    end else begin
      state <= nxt;
      cap_a <= a_d;
      cap_b <= b_d;
      cap_op <= op_d;
      if (state == R_CAP) begin
        result <= s.bus_in;
        flags <= {s.fl_z, s.fl_lt, s.fl_carry};
      end
    end
  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:  nxt = accept ? (s.skip_ab ? X_SET : A_SET) : IDLE;
      A_SET: nxt = A_CAP;
      A_CAP: nxt = B_SET;
      B_SET: nxt = B_CAP;
      B_CAP: nxt = X_SET;
      X_SET: nxt = X_CAP;
      X_CAP: nxt = F_CAP;
      F_CAP: nxt = R_SET;
      R_SET: nxt = R_CAP;
      R_CAP: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  alu_seq_strobe_gen u_strobe (
    .clk(clk), .rst(rst), .nxt(nxt), .a(a_d), .b(b_d), .op(op_d),
    .bus_out(s.bus_out), .bus_oe_n(s.bus_oe_n), .a_r(s.a_r), .b_r(s.b_r),
    .o_r(s.o_r), .flb_r(s.flb_r), .fl_r(s.fl_r), .o_w(s.o_w),
    .busy(s.busy), .done(s.done)
  );
  assign s.a_bus = 1'b1;
  assign s.b_bus = 1'b1;
  assign s.result = result;
  assign s.flags = flags;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed runs of alu_sequencer against a small behavioural ALU/register-file stand-in
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_seq_if s();
  alu_sequencer dut (.clk(clk), .rst(rst), .s(s.master));
  int n_vec = 0;
  int n_bad = 0;
  int a_rises = 0;
  int b_rises = 0;
  logic [7:0] ma = '0, mb = '0, mres = '0, pbus = '0;
  logic [2:0] mflb = '0, mfl = '0;
  logic pa = 1'b0, pb = 1'b0, po = 1'b0, pf = 1'b0, poe = 1'b1;
  assign s.bus_in = !s.o_w ? mres : !s.bus_oe_n ? s.bus_out : 8'hff;
  assign s.fl_carry = mfl[FL_CARRY];
  assign s.fl_lt = mfl[FL_LT];
  assign s.fl_z = mfl[FL_Z];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] alu(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = o == OP_SUB ? {1'b0, a} + {1'b0, ~b} + 9'd1 :
        o == OP_NAND ? {1'b0, ~(a & b)} : {1'b0, a} + {1'b0, b};
    return {t[7:0] == 8'h00, a < b, t[8], t[7:0]};
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      chk("bus_excl", {31'd0, !s.bus_oe_n && !s.o_w}, 0);
      if (s.a_r && !pa) begin
        ma <= s.bus_out;
        a_rises <= a_rises + 1;
        chk("a_stable", {24'd0, s.bus_out}, {24'd0, pbus});
        chk("a_set_oe", {31'd0, poe}, 0);
      end
      if (s.b_r && !pb) begin
        mb <= s.bus_out;
        b_rises <= b_rises + 1;
        chk("b_stable", {24'd0, s.bus_out}, {24'd0, pbus});
        chk("b_set_oe", {31'd0, poe}, 0);
      end
      if (s.o_r && !po) begin
        mres <= alu(s.bus_out, ma, mb)[7:0];
        mflb <= alu(s.bus_out, ma, mb)[10:8];
        chk("x_stable", {24'd0, s.bus_out}, {24'd0, pbus});
        chk("x_flb_with_o", {31'd0, s.flb_r}, 1);
      end
      if (s.fl_r && !pf) mfl <= mflb;
    end
    pa <= s.a_r;
    pb <= s.b_r;
    po <= s.o_r;
    pf <= s.fl_r;
    poe <= s.bus_oe_n;
    pbus <= s.bus_out;
  end
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (s.done) break;
      @(posedge clk);
      n++;
    end
    chk(tag, n, exp_lat);
  endtask
  task automatic run(input logic skip, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_res, input logic [2:0] exp_fl, input int exp_lat);
    @(negedge clk);
    s.skip_ab = skip;
    s.op = op;
    s.operand_a = a;
    s.operand_b = b;
    s.start = 1'b1;
    @(posedge clk);
    #1;
    s.start = 1'b0;
    s.op = 8'ha5;
    s.operand_a = 8'h5a;
    s.operand_b = 8'hc3;
    wait_done("latency", exp_lat);
    chk("result", {24'd0, s.result}, {24'd0, exp_res});
    chk("flags", {29'd0, s.flags}, {29'd0, exp_fl});
    @(negedge clk);
    chk("done_pulse", {30'd0, s.done, s.busy}, 0);
    chk("result_hold", {24'd0, s.result}, {24'd0, exp_res});
  endtask
  initial begin
    int a0, b0;
    s.start = 1'b0;
    s.skip_ab = 1'b0;
    s.op = '0;
    s.operand_a = '0;
    s.operand_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {27'd0, s.a_r, s.b_r, s.o_r, s.flb_r, s.fl_r}, 0);
    chk("rst_oe_ow", {30'd0, s.bus_oe_n, s.o_w}, 3);
    chk("rst_abus", {30'd0, s.a_bus, s.b_bus}, 3);
    chk("rst_bus_out", {24'd0, s.bus_out}, 0);
    chk("rst_busy_done", {30'd0, s.busy, s.done}, 0);
    chk("rst_res_fl", {21'd0, s.result, s.flags}, 0);
    rst = 1'b0;
    @(negedge clk);
    s.op = OP_ADD;
    s.operand_a = 8'h11;
    s.operand_b = 8'h22;
    s.start = 1'b1;
    @(posedge clk);
    #1;
    s.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bcap_b_r", {31'd0, s.b_r}, 1);
    chk("bcap_bus", {24'd0, s.bus_out}, 32'h22);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_strobes", {27'd0, s.a_r, s.b_r, s.o_r, s.flb_r, s.fl_r}, 0);
    chk("abort_oe_ow", {30'd0, s.bus_oe_n, s.o_w}, 3);
    chk("abort_busy_done", {30'd0, s.busy, s.done}, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", {31'd0, s.done}, 0);
    rst = 1'b0;
    run(1'b0, OP_ADD, 8'h3c, 8'h05, 8'h41, 3'b000, 10);
    run(1'b0, OP_SUB, 8'h05, 8'h05, 8'h00, 3'b101, 10);
    a0 = a_rises;
    b0 = b_rises;
    run(1'b1, OP_ADD, 8'h77, 8'h99, 8'h0a, 3'b000, 6);
    chk("skip_no_a_r", a_rises - a0, 0);
    chk("skip_no_b_r", b_rises - b0, 0);
    run(1'b0, OP_NAND, 8'hf0, 8'h3c, 8'hcf, 3'b000, 10);
    run(1'b0, OP_SUB, 8'h03, 8'h07, 8'hfc, 3'b010, 10);
    @(negedge clk);
    s.skip_ab = 1'b1;
    s.op = OP_ADD;
    s.start = 1'b1;
    @(posedge clk);
    wait_done("b2b_lat1", 6);
    chk("b2b_res1", {24'd0, s.result}, 32'h0a);
    chk("b2b_fl1", {29'd0, s.flags}, 32'h2);
    @(negedge clk);
    chk("b2b_idle", {31'd0, s.busy}, 0);
    @(posedge clk);
    wait_done("b2b_lat2", 6);
    s.start = 1'b0;
    chk("b2b_res2", {24'd0, s.result}, 32'h0a);
    @(negedge clk);
    chk("b2b_end_idle", {31'd0, s.busy}, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control-side initiator for the ALU datapath. It drives the shared 8-bit bus and the register strobes that main_reg, alu_decoder and alu_reg respond to. One start request runs a fixed micro-sequence:
- load A, then load B, from supplied operands;
- present the op byte on the bus to the decoder;
- latch the result and flags;
- read the result back off the bus into a local result register.
It sits between the instruction/control logic and the ALU register file.

Parameters:
- BUS_W, 8, bus and operand width; the datapath is fixed at 8 and no other value is supported.
- FLAG_W, 3, number of flags captured: carry, lt, z.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- skip_ab  in  1  sampled with start; 1 = reuse the A/B already held and go straight to execute.
- op  in  8  ALU op byte in decoder encoding; captured at start.
- operand_a  in  8  A value; captured at start.
- operand_b  in  8  B value; captured at start.
- bus_in  in  8  current bus value, used for readback.
- fl_carry, fl_lt, fl_z  in  1 each  flag outputs from alu_reg.
- bus_out  out  8  value driven onto the bus.
- bus_oe_n  out  1  bus drive enable, active-low.
- a_r, b_r  out  1 each  A/B register load strobes; the rising edge latches.
- o_r, flb_r, fl_r  out  1 each  result, flag-buffer and flag register strobes; the rising edge latches.
- o_w  out  1  result-register bus drive, active-low.
- a_bus, b_bus  out  1 each  A/B bus drive, active-low; held 1 permanently.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result/flags are valid.
- result  out  8  captured ALU result.
- flags  out  3  captured {z, lt, carry}.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE;
  - a_r = b_r = o_r = flb_r = fl_r = 0;
  - bus_oe_n = 1, o_w = 1, a_bus = b_bus = 1;
  - bus_out = 0, busy = 0, done = 0;
  - result = 0, flags = 0;
  - captured op and operands cleared.
- Reset mid-sequence aborts immediately and releases the bus; done is not asserted.
- All outputs are registered, so there are no glitches on the strobes.
- Strobe rule: a strobe is 0 in the SET cycle and 1 in the CAP cycle. The latching rising edge therefore coincides with entry to CAP, and the bus is stable in both the SET and CAP cycles.
- Start acceptance:
  - In IDLE with start=1, capture op/operand_a/operand_b/skip_ab.
  - Next state is A_SET, or X_SET if skip_ab=1.
- States and outputs (each state lasts one cycle):
  - A_SET: bus_out=A, oe_n=0, a_r=0.
  - A_CAP: bus_out=A, oe_n=0, a_r=1.
  - B_SET: bus_out=B, oe_n=0, a_r=0, b_r=0.
  - B_CAP: bus_out=B, oe_n=0, b_r=1.
  - X_SET: bus_out=op, oe_n=0, b_r=0.
  - X_CAP: bus_out=op, oe_n=0, o_r=1, flb_r=1.
  - F_CAP: oe_n=1, o_r=0, flb_r=0, fl_r=1.
  - R_SET: fl_r=0, o_w=0.
  - R_CAP: o_w=0; result<=bus_in; flags<={fl_z,fl_lt,fl_carry}.
  - DONE: o_w=1, done=1, then IDLE.
- Latency:
  - start at edge k gives done high in cycle k+10.
  - With skip_ab, done is high in cycle k+6.
- Bus exclusivity: bus_oe_n=0 and o_w=0 are never asserted in the same cycle. F_CAP is the turnaround cycle between the two drivers.
- Input timing:
  - start is ignored when not in IDLE, including the DONE cycle. Back-to-back requests therefore see a minimum 1 IDLE cycle between runs.
  - Changes to op/operands after capture have no effect on the run in progress.
- result and flags hold their values until the next R_CAP or reset.
- Wrap-around and overflow are the ALU's concern. The sequencer passes 8-bit values unmodified.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, A_SET, A_CAP, B_SET, B_CAP, X_SET, X_CAP, F_CAP, R_SET, R_CAP, DONE);
  - op-byte constants OP_ADD=8'h20, OP_SUB=8'h60, OP_NAND=8'h30;
  - flag bit indices.
- One sub-module, alu_seq_strobe_gen: a registered decode from state to the strobe and enable outputs, kept apart from the next-state logic.

Test Plan:
1. Reset asserted mid-run in B_CAP -> immediately all strobes 0, bus_oe_n=1, o_w=1, busy=0; no done; the next start runs normally.
2. start, op=0x20, A=0x3C, B=0x05, with real ALU/regs -> done at k+10, result=0x41, flags=3'b000.
3. start, op=0x60, A=0x05, B=0x05 -> result=0x00, flags z=1, carry=1, i.e. 3'b101.
4. After run 3, start with skip_ab=1 and op=0x20 (operands ignored) -> done at k+6, result=0x0A; a_r and b_r show no edge.
5. start held high continuously -> runs separated by exactly one IDLE cycle; start during busy is ignored.
6. Every cycle of every run -> bus_oe_n and o_w are never both 0; each strobe rises only when entering its CAP state, with bus_out stable in the SET cycle before.
